// File: rtl/phase_calib_pkg.sv
// Shared types and defaults for the phase calibration loader.
package phase_calib_pkg;

  typedef logic [7:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    SETTLE
  } calib_state_e;

  localparam int unsigned SETTLE_CYCLES_DEF  = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  // Bits needed to hold the value max_val itself (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/phase_calib_timer.sv
// Loadable down-counter with a zero flag and an "expires on this decrement" flag.
module phase_calib_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero   = (count == '0);
  // Callers never decrement at zero, so 1 -> 0 is the expiry step.
  assign expire = dec && (count == WIDTH'(1));

endmodule

// File: rtl/phase_calib_loader.sv
// Collects one phase byte per channel into a shadow array and commits the full set atomically.
// Optional inter-byte timeout in LOAD is enabled by defining PHASE_CALIB_TIMEOUT_EN.
module phase_calib_loader
  import phase_calib_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                cal_data,
  input  logic                      cal_valid,
  output logic                      cal_ready,
  output logic [8*NUM_CHANNELS-1:0] phases_calib,
  output logic                      phase_calib_en,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned      IDX_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam int unsigned      ST_W     = cnt_width(SETTLE_CYCLES);

  calib_state_e     state, state_next;
  logic [IDX_W-1:0] idx;
  phase_t           shadow [NUM_CHANNELS];

  logic handshake, accept, last_byte, kill, timeout;
  logic settle_zero, settle_expire;

  // Handshake outputs come straight from the state register.
  assign cal_ready      = (state == LOAD);
  assign busy           = (state != IDLE);
  assign phase_calib_en = (state == COMMIT);

  assign handshake = cal_ready && cal_valid;
  assign kill      = (state == LOAD) && (abort || timeout);
  assign accept    = handshake && !kill;
  assign last_byte = accept && (idx == LAST_IDX);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = LOAD;
      LOAD: begin
        if (kill)           state_next = IDLE;
        else if (last_byte) state_next = COMMIT;
      end
      COMMIT: state_next = SETTLE;
      SETTLE: if (settle_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == SETTLE) && settle_expire;
      err   <= kill;
    end
  end

  // Index stops at the last channel; COMMIT is taken instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if ((state == IDLE) && start) begin
      idx <= '0;
    end else if (accept && !last_byte) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // NOTE: the shadow array is small and must read as zero after reset, so it is reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) shadow[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        if (idx == IDX_W'(k)) shadow[k] <= cal_data;
    end
  end

  // Committed set is registered on the edge entering COMMIT so it is valid alongside phase_calib_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phases_calib <= '0;
    end else if (last_byte) begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        phases_calib[8*k +: 8] <= (k == NUM_CHANNELS - 1) ? cal_data : shadow[k];
    end
  end

  phase_calib_timer #(.WIDTH(ST_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == COMMIT),
    .load_val (ST_W'(SETTLE_CYCLES)),
    .dec      ((state == SETTLE) && !settle_zero),
    .zero     (settle_zero),
    .expire   (settle_expire)
  );

`ifdef PHASE_CALIB_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_width(TIMEOUT_CYCLES);
  logic gap_zero;

  // Gap counter restarts on entry to LOAD and on every offered byte.
  phase_calib_timer #(.WIDTH(TO_W)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (((state == IDLE) && start) || handshake),
    .load_val (TO_W'(TIMEOUT_CYCLES)),
    .dec      ((state == LOAD) && !handshake && !gap_zero),
    .zero     (gap_zero),
    .expire   (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_phase_calib_loader.sv
// Directed self-checking bench for phase_calib_loader (channel k at phases_calib[8k+:8]).
module tb_phase_calib_loader;

  localparam int N = 4;
`ifdef PHASE_CALIB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, abort, cal_valid;
  logic [7:0]     cal_data;
  logic           cal_ready, phase_calib_en, busy, done, err;
  logic [8*N-1:0] phases_calib;

  int errors = 0;
  int checks = 0;

  phase_calib_loader #(
    .NUM_CHANNELS   (N),
    .SETTLE_CYCLES  (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cal_data       (cal_data),
    .cal_valid      (cal_valid),
    .cal_ready      (cal_ready),
    .phases_calib   (phases_calib),
    .phase_calib_en (phase_calib_en),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    cal_valid = 1'b1;
    cal_data  = b;
    tick();
    cal_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] gap_bytes [4];

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cal_valid = 1'b0; cal_data = 8'h00;
    gap_bytes[0] = 8'hFE; gap_bytes[1] = 8'hFF; gap_bytes[2] = 8'h00; gap_bytes[3] = 8'h7F;
    tick();
    tick();
    check("rst_busy",   busy,           0);
    check("rst_ready",  cal_ready,      0);
    check("rst_en",     phase_calib_en, 0);
    check("rst_done",   done,           0);
    check("rst_err",    err,            0);
    check("rst_phases", phases_calib,   32'h0);
    rst_n = 1'b1;
    tick();

    // Back-to-back load 01..04.
    do_start();
    check("t1_busy",  busy,      1);
    check("t1_ready", cal_ready, 1);
    send(8'h01); send(8'h02); send(8'h03);
    check("t1_no_early_en", phase_calib_en, 0);
    send(8'h04);
    check("t1_en",       phase_calib_en, 1);
    check("t1_phases",   phases_calib,   32'h04030201);
    check("t1_ready_lo", cal_ready,      0);
    tick();
    check("t1_en_once",  phase_calib_en, 0);
    check("t1_busy_set", busy,           1);
    check("t1_no_done1", done,           0);
    tick();
    check("t1_no_done2", done,           0);
    tick();
    check("t1_done",     done,           1);
    check("t1_idle",     busy,           0);
    check("t1_phases_h", phases_calib,   32'h04030201);
    tick();
    check("t1_done_pls", done,           0);

    // Gapped bytes FE,FF,00,7F with three idle cycles before each.
    do_start();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 3; g++) begin
        tick();
        check("t2_busy",  busy,           1);
        check("t2_no_en", phase_calib_en, 0);
      end
      check("t2_old_phases", phases_calib, 32'h04030201);
      send(gap_bytes[i]);
    end
    check("t2_en",     phase_calib_en, 1);
    check("t2_phases", phases_calib,   32'h7F00FFFE);
    tick(); tick(); tick();
    check("t2_done",   done,           1);

    // Abort arriving together with the fourth byte.
    do_start();
    send(8'h11); send(8'h22); send(8'h33);
    abort = 1'b1;
    send(8'h44);
    abort = 1'b0;
    check("t3_err",    err,            1);
    check("t3_idle",   busy,           0);
    check("t3_no_en",  phase_calib_en, 0);
    check("t3_phases", phases_calib,   32'h7F00FFFE);
    tick();
    check("t3_err_pls", err,            0);
    check("t3_no_en2",  phase_calib_en, 0);
    check("t3_phases2", phases_calib,   32'h7F00FFFE);

    // start held through COMMIT and SETTLE is ignored.
    do_start();
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    start = 1'b1;
    check("t4_en", phase_calib_en, 1);
    tick();
    check("t4_settle", busy, 1);
    tick();
    tick();
    check("t4_done",   done, 1);
    check("t4_idle",   busy, 0);
    start = 1'b0;
    tick();
    check("t4_not_queued", busy, 0);
    check("t4_single_done", done, 0);
    check("t4_phases", phases_calib, 32'hA4A3A2A1);

    // Reset in the middle of LOAD.
    do_start();
    send(8'hC1); send(8'hC2);
    rst_n = 1'b0;
    #1;
    check("t5_busy",   busy,         0);
    check("t5_ready",  cal_ready,    0);
    check("t5_phases", phases_calib, 32'h0);
    check("t5_done",   done,         0);
    check("t5_err",    err,          0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    send(8'h5A); send(8'h6B); send(8'h7C); send(8'h8D);
    check("t5_en",      phase_calib_en, 1);
    check("t5_phases2", phases_calib,   32'h8D7C6B5A);
    tick(); tick(); tick();
    check("t5_done2",   done,           1);

    // Stall after the first byte.
    do_start();
    send(8'h99);
`ifdef PHASE_CALIB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t6_no_err", err,  0);
      check("t6_busy",   busy, 1);
    end
    tick();
    check("t6_err",  err,  1);
    check("t6_idle", busy, 0);
`else
    for (int i = 0; i < 12; i++) tick();
    check("t6_err",   err,       0);
    check("t6_busy",  busy,      1);
    check("t6_ready", cal_ready, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_err", err,  1);
    check("t6_idle",      busy, 0);
`endif
    check("t6_phases", phases_calib, 32'h8D7C6B5A);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_calib_loader.md
# phase_calib_loader

Sequencer that loads one calibration phase per transducer channel from a byte stream (UART command decoder) and commits the full set atomically to the phase calibration datapath. Bytes are collected into a shadow array. Only after all NUM_CHANNELS bytes arrive is the committed array updated and `phase_calib_en` pulsed for one cycle. The block then holds off for the datapath's pipeline depth before reporting done, so downstream phase updates never see a half-written calibration set.

## Interface
- `NUM_CHANNELS`, 4: number of transducer channels, ≥1.
- `SETTLE_CYCLES`, 2: cycles to wait after commit (calibration datapath register depth), ≥1.
- `TIMEOUT_CYCLES`, 1024: max idle gap between bytes in LOAD (used only with the timeout feature).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin a load; sampled only in IDLE.
- `abort`  in  1  cancel an in-progress load.
- `cal_data`  in  8  calibration phase byte.
- `cal_valid`  in  1  `cal_data` valid.
- `cal_ready`  out  1  loader accepts a byte this cycle.
- `phases_calib`  out  8 × NUM_CHANNELS  committed calibration array, to the datapath's `phases_in`.
- `phase_calib_en`  out  1  one-cycle commit strobe to the datapath.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a load completes successfully.
- `err`  out  1  one-cycle pulse on abort or timeout.

## Operation
- States: IDLE, LOAD, COMMIT, SETTLE.
- **IDLE**
  - `cal_ready=0`.
  - `start=1` → LOAD, index cleared to 0.
- **LOAD**
  - `cal_ready=1`.
  - Each `cal_valid && cal_ready` writes `shadow[index]=cal_data` and increments the index.
  - The k-th accepted byte goes to channel k.
  - On acceptance of byte NUM_CHANNELS-1 → COMMIT.
- **COMMIT** (exactly 1 cycle)
  - `phases_calib <= shadow` (registered).
  - `phase_calib_en=1`.
  - `cal_ready=0`.
  - → SETTLE, settle counter loaded with SETTLE_CYCLES.
- **SETTLE**
  - Counter decrements each cycle.
  - When it reaches 0: `done=1` for that cycle, → IDLE.
- `abort` in LOAD: → IDLE, `err=1` for one cycle.
  - The shadow array is left partially written.
  - `phases_calib` is unchanged.
- `abort` in IDLE, COMMIT or SETTLE is ignored. A commit always finishes once begun.
- `start` outside IDLE is ignored; it is not queued.
- Same cycle as a handshake:
  - `abort` with `cal_valid` in LOAD: abort wins, the byte is not written, no commit happens even if it was the last byte.
  - `start` with `cal_valid` in IDLE: the byte is not accepted (`cal_ready=0`).
- Index width is `$clog2(NUM_CHANNELS)`, or 1 if NUM_CHANNELS=1. The index never wraps, because COMMIT is taken at NUM_CHANNELS-1.
- `phases_calib` changes only in COMMIT. It is stable in every other state.

## Timing
- Reset values, asserted asynchronously and released synchronously to `clk`:
  - state IDLE, index 0, shadow all 0.
  - `phases_calib` all 0.
  - `cal_ready`, `phase_calib_en`, `busy`, `done`, `err` all 0.
- `cal_ready`, `busy` and `phase_calib_en` are decoded from registered state, with no combinational path from inputs.
- `start` at edge t → `busy=1` and `cal_ready=1` from t+1.
- Last byte accepted at edge t:
  - COMMIT during cycle t..t+1: `phase_calib_en=1`, `phases_calib` valid from t+1.
  - `done` pulses in the cycle after SETTLE_CYCLES SETTLE cycles, i.e. edge t+1+SETTLE_CYCLES.
  - Back to IDLE after that edge.
- Minimum full load: NUM_CHANNELS + 2 + SETTLE_CYCLES cycles from `start`.
- Reset mid-operation (any state): immediate return to reset values. No `done` or `err` pulse.

## Configuration
- `PHASE_CALIB_TIMEOUT_EN` defined:
  - A gap counter in LOAD counts cycles without an accepted byte, cleared on each acceptance and on entry to LOAD.
  - Reaching TIMEOUT_CYCLES has the same effect as `abort`: → IDLE, `err` pulse.
- Not defined: no counter is instantiated, and LOAD waits indefinitely.
- Port list is identical in both builds.

## Structure
- Package `phase_calib_pkg` holds:
  - `typedef logic [7:0] phase_t`.
  - State enum `calib_state_e` with values IDLE, LOAD, COMMIT, SETTLE.
  - Default localparams for SETTLE_CYCLES and TIMEOUT_CYCLES.
- One sub-module, `phase_calib_timer`: a load/decrement/zero-flag down-counter, instanced for SETTLE and, under the macro, for the timeout.

## Test plan
- Reset, then `start`, bytes 01,02,03,04 back-to-back.
  - `phase_calib_en` is high exactly 1 cycle and `phases_calib`={01,02,03,04} from that cycle.
  - `done` 2 cycles later.
  - Total 8 cycles from `start`.
- Bytes FE,FF,00,7F with `cal_valid` gaps of 3 cycles.
  - Exact array committed, no early commit, `busy` high throughout.
- Load 3 bytes, then `abort` together with a 4th `cal_valid`.
  - `err` pulse, no `phase_calib_en`, `phases_calib` keeps its prior value.
- `start` pulsed during SETTLE and COMMIT: ignored, and a single `done` follows.
- `rst_n` low mid-LOAD after 2 bytes: all outputs return to 0 immediately; a new load afterwards commits correctly.
- With `PHASE_CALIB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, a stall after byte 1:
  - `err` 8 cycles after the last acceptance, state IDLE.
  - Without the macro, the same stall stays in LOAD.
